// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with counter-based occupancy, almost-full/empty flags and
// synchronous flush. Define FIFO_ERR_FLAGS_EN to add sticky OVF/UDF error flags.
module fifo_sync_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic                   CLEAR_N,
  input  logic                   WRITE,
  input  logic                   READ,
  input  logic [WIDTH-1:0]       DATA_IN,
  output logic [WIDTH-1:0]       DATA_OUT,
  output logic                   F_FULL_N,
  output logic                   F_EMPTY_N,
  output logic                   F_AFULL_N,
  output logic                   F_AEMPTY_N,
  output logic [$clog2(DEPTH):0] USE_DW
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                   OVF,
  output logic                   UDF
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] CntFull       = CW'(DEPTH);
  localparam logic [CW-1:0] CntAlmostFull = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CntOne        = CW'(1);
  localparam logic [CW-1:0] CntAf         = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CntAe         = CW'(AE_LEVEL);
  localparam logic          AfullNRst     = (AF_LEVEL != 0);

  typedef enum logic [1:0] {
    StEmpty   = 2'd0,
    StPartial = 2'd1,
    StFull    = 2'd2
  } state_e;

  state_e           state_q;
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_n_q, full_n_q;
  logic             afull_n_q, aempty_n_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rd_acc, wr_acc;

  // A write into a full FIFO is still accepted when a read frees the slot on the same edge.
  always_comb begin
    rd_acc = CLEAR_N & READ & (state_q != StEmpty);
    wr_acc = CLEAR_N & WRITE & ((state_q != StFull) | rd_acc);
  end

  always_comb begin
    count_d = count_q;
    if (!CLEAR_N) begin
      count_d = '0;
    end else if (wr_acc && !rd_acc) begin
      count_d = count_q + CntOne;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (!CLEAR_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + AW'(1);
      if (rd_acc) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Control FSM; empty/full outputs are registered alongside the state.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StEmpty;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else if (!CLEAR_N) begin
      state_q   <= StEmpty;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (wr_acc) begin
            state_q   <= StPartial;
            empty_n_q <= 1'b1;
          end
        end
        StPartial: begin
          if (wr_acc && !rd_acc && (count_q == CntAlmostFull)) begin
            state_q  <= StFull;
            full_n_q <= 1'b0;
          end else if (rd_acc && !wr_acc && (count_q == CntOne)) begin
            state_q   <= StEmpty;
            empty_n_q <= 1'b0;
          end
        end
        StFull: begin
          if (rd_acc && !wr_acc) begin
            state_q  <= StPartial;
            full_n_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= StEmpty;
          empty_n_q <= 1'b0;
          full_n_q  <= 1'b1;
        end
      endcase
    end
  end

  // Threshold flags look at the next count so they change on the same edge as USE_DW.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      afull_n_q  <= AfullNRst;
      aempty_n_q <= 1'b0;
    end else begin
      afull_n_q  <= ~(count_d >= CntAf);
      aempty_n_q <= ~(count_d <= CntAe);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (wr_acc) mem_q[wptr_q] <= DATA_IN;
  end

  // Read-before-write: with a full FIFO read and write hit the same slot, old data is returned.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem_q[rptr_q];
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (!CLEAR_N) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (WRITE && !wr_acc) ovf_q <= 1'b1;
      if (READ && !rd_acc)  udf_q <= 1'b1;
    end
  end

  assign OVF = ovf_q;
  assign UDF = udf_q;
`endif

  assign DATA_OUT   = dout_q;
  assign F_FULL_N   = full_n_q;
  assign F_EMPTY_N  = empty_n_q;
  assign F_AFULL_N  = afull_n_q;
  assign F_AEMPTY_N = aempty_n_q;
  assign USE_DW     = count_q;

`ifndef SYNTHESIS
  a_empty_agrees: assert property (@(posedge CLOCK) disable iff (!RESET_N)
    F_EMPTY_N == (count_q != '0));
  a_full_agrees: assert property (@(posedge CLOCK) disable iff (!RESET_N)
    F_FULL_N == (count_q != CntFull));
  a_count_bound: assert property (@(posedge CLOCK) disable iff (!RESET_N)
    count_q <= CntFull);
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param (WIDTH=8, DEPTH=32, AF=28, AE=4); OVF/UDF checked when
// FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_sync_param;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       CLEAR_N = 1'b1;
  logic       WRITE = 1'b0;
  logic       READ = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic [7:0] DATA_OUT;
  logic       F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N;
  logic [5:0] USE_DW;
`ifdef FIFO_ERR_FLAGS_EN
  logic       OVF, UDF;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] m_dout = 8'h00;
  logic [7:0] got;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  fifo_sync_param #(
    .WIDTH   (8),
    .DEPTH   (32),
    .AF_LEVEL(28),
    .AE_LEVEL(4)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .CLEAR_N   (CLEAR_N),
    .WRITE     (WRITE),
    .READ      (READ),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .F_FULL_N  (F_FULL_N),
    .F_EMPTY_N (F_EMPTY_N),
    .F_AFULL_N (F_AFULL_N),
    .F_AEMPTY_N(F_AEMPTY_N),
    .USE_DW    (USE_DW)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .OVF       (OVF),
    .UDF       (UDF)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  // One clock of stimulus; the queue model decides acceptance and pushes expected read data.
  task automatic drive(input logic wr, input logic rd, input logic [7:0] din, input logic clr);
    logic rd_ok, wr_ok;
    WRITE   = wr;
    READ    = rd;
    DATA_IN = din;
    CLEAR_N = ~clr;
    @(posedge CLOCK);
    if (clr) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd_ok = rd && (model_q.size() > 0);
      wr_ok = wr && ((model_q.size() < 32) || rd_ok);
      if (rd_ok) begin
        m_dout = model_q.pop_front();
        exp_q.push_back(m_dout);
      end
      if (wr_ok) model_q.push_back(din);
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd && !rd_ok) m_udf = 1'b1;
    end
    #1;
    WRITE   = 1'b0;
    READ    = 1'b0;
    CLEAR_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    n_checks++;
    if (USE_DW !== 6'd0 || DATA_OUT !== 8'h00)
      $display("FAIL reset_data use_dw=%0d data_out=%h want 0 00", USE_DW, DATA_OUT);
    else n_pass++;
    n_checks++;
    if ({F_EMPTY_N, F_FULL_N, F_AEMPTY_N, F_AFULL_N} !== 4'b0101)
      $display("FAIL reset_flags e/f/ae/af=%b want 0101",
               {F_EMPTY_N, F_FULL_N, F_AEMPTY_N, F_AFULL_N});
    else n_pass++;
    @(negedge CLOCK);
    RESET_N = 1'b1;
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b0, 8'hA1, 1'b0);
    drive(1'b1, 1'b0, 8'hB2, 1'b0);
    drive(1'b1, 1'b0, 8'hC3, 1'b0);
    n_checks++;
    if (USE_DW !== 6'd3) $display("FAIL basic_count got %0d want 3", USE_DW);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      got = exp_q.pop_front();
      n_checks++;
      if (DATA_OUT !== got || USE_DW !== 6'(2 - i))
        $display("FAIL basic_read%0d data=%h cnt=%0d want %h %0d", i, DATA_OUT, USE_DW, got, 2 - i);
      else n_pass++;
    end
    n_checks++;
    if (F_EMPTY_N !== 1'b0) $display("FAIL basic_empty F_EMPTY_N=%b want 0", F_EMPTY_N);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 8'(i), 1'b0);
      n_checks++;
      if (F_AFULL_N !== (i + 1 < 28) || F_AEMPTY_N !== (i + 1 > 4) || USE_DW !== 6'(i + 1))
        $display("FAIL fill_up n=%0d af_n=%b ae_n=%b cnt=%0d want %b %b %0d", i + 1, F_AFULL_N,
                 F_AEMPTY_N, USE_DW, (i + 1 < 28), (i + 1 > 4), i + 1);
      else n_pass++;
    end
    n_checks++;
    if (F_FULL_N !== 1'b0) $display("FAIL fill_full F_FULL_N=%b want 0", F_FULL_N);
    else n_pass++;
    drive(1'b1, 1'b0, 8'hFF, 1'b0);
    n_checks++;
    if (USE_DW !== 6'd32 || F_FULL_N !== 1'b0)
      $display("FAIL overflow_drop cnt=%0d full_n=%b want 32 0", USE_DW, F_FULL_N);
    else n_pass++;
`ifdef FIFO_ERR_FLAGS_EN
    n_checks++;
    if (OVF !== m_ovf) $display("FAIL ovf_set got %b want %b", OVF, m_ovf);
    else n_pass++;
`endif
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      got = exp_q.pop_front();
      n_checks++;
      if (DATA_OUT !== got || F_AFULL_N !== (31 - i < 28) || F_AEMPTY_N !== (31 - i > 4))
        $display("FAIL drain n=%0d data=%h af_n=%b ae_n=%b want %h %b %b", 31 - i, DATA_OUT,
                 F_AFULL_N, F_AEMPTY_N, got, (31 - i < 28), (31 - i > 4));
      else n_pass++;
    end
    n_checks++;
    if (F_EMPTY_N !== 1'b0 || USE_DW !== 6'd0)
      $display("FAIL drain_empty empty_n=%b cnt=%0d want 0 0", F_EMPTY_N, USE_DW);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
      got = exp_q.pop_front();
      n_checks++;
      if (DATA_OUT !== got || USE_DW !== 6'd32)
        $display("FAIL b2b_%0d data=%h cnt=%0d want %h 32", i, DATA_OUT, USE_DW, got);
      else n_pass++;
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      got = exp_q.pop_front();
      n_checks++;
      if (DATA_OUT !== got) $display("FAIL b2b_drain%0d data=%h want %h", i, DATA_OUT, got);
      else n_pass++;
    end
  endtask

  task automatic test_empty_rw();
    drive(1'b1, 1'b1, 8'h5A, 1'b0);
    n_checks++;
    if (USE_DW !== 6'd1 || DATA_OUT !== m_dout || exp_q.size() != 0)
      $display("FAIL empty_rw cnt=%0d data=%h want 1 %h", USE_DW, DATA_OUT, m_dout);
    else n_pass++;
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    got = exp_q.pop_front();
    n_checks++;
    if (DATA_OUT !== got || got !== 8'h5A)
      $display("FAIL empty_rw_read data=%h want 5a", DATA_OUT);
    else n_pass++;
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    n_checks++;
    if (DATA_OUT !== m_dout || USE_DW !== 6'd0)
      $display("FAIL underflow_hold data=%h cnt=%0d want %h 0", DATA_OUT, USE_DW, m_dout);
    else n_pass++;
`ifdef FIFO_ERR_FLAGS_EN
    n_checks++;
    if (UDF !== m_udf) $display("FAIL udf_set got %b want %b", UDF, m_udf);
    else n_pass++;
`endif
  endtask

  task automatic test_clear();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    drive(1'b1, 1'b0, 8'h77, 1'b1);
    n_checks++;
    if (USE_DW !== 6'd0 || F_EMPTY_N !== 1'b0 || F_AEMPTY_N !== 1'b0 || DATA_OUT !== m_dout)
      $display("FAIL clear cnt=%0d empty_n=%b ae_n=%b data=%h want 0 0 0 %h", USE_DW, F_EMPTY_N,
               F_AEMPTY_N, DATA_OUT, m_dout);
    else n_pass++;
`ifdef FIFO_ERR_FLAGS_EN
    n_checks++;
    if (OVF !== m_ovf || UDF !== m_udf)
      $display("FAIL clear_err ovf=%b udf=%b want %b %b", OVF, UDF, m_ovf, m_udf);
    else n_pass++;
`endif
    drive(1'b1, 1'b0, 8'h3C, 1'b0);
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    got = exp_q.pop_front();
    n_checks++;
    if (DATA_OUT !== got || got !== 8'h3C) $display("FAIL clear_new data=%h want 3c", DATA_OUT);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    model_q.delete();
    exp_q.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    n_checks++;
    if (USE_DW !== 6'd0 || DATA_OUT !== 8'h00 ||
        {F_EMPTY_N, F_FULL_N, F_AEMPTY_N, F_AFULL_N} !== 4'b0101)
      $display("FAIL async_reset cnt=%0d data=%h e/f/ae/af=%b want 0 00 0101", USE_DW, DATA_OUT,
               {F_EMPTY_N, F_FULL_N, F_AEMPTY_N, F_AFULL_N});
    else n_pass++;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    drive(1'b1, 1'b0, 8'h99, 1'b0);
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    got = exp_q.pop_front();
    n_checks++;
    if (DATA_OUT !== got || got !== 8'h99) $display("FAIL post_reset data=%h want 99", DATA_OUT);
    else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_fill_drain();
    test_back_to_back();
    test_empty_rw();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
